// File: rtl/snn_pkg.sv
// Shared constants and types for the ANN<->SNN conversion blocks.
package snn_pkg;
    localparam int TIMESTEPS_DEF = 4;

    // Wide enough for acc + v, where both are bounded by TIMESTEPS.
    function automatic int acc_width(input int t);
        return $clog2(t) + 2;
    endfunction

    typedef enum logic {IDLE, ENCODE} enc_state_t;
endpackage

// File: rtl/ann_to_snn_if_neuron.sv
// One integrate-and-fire neuron: saturated activation plus accumulator.
// spike is combinational and is the value the top registers on load/step.
module ann_to_snn_if_neuron
    import snn_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int TIMESTEPS = TIMESTEPS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] act,
    input  logic             load,
    input  logic             step,
    output logic             spike
);
    localparam int ACC_W = acc_width(TIMESTEPS);
    localparam int CW    = (WIDTH > ACC_W) ? WIDTH : ACC_W;
    localparam logic [CW-1:0]    T_X = CW'(TIMESTEPS);
    localparam logic [ACC_W-1:0] T_A = ACC_W'(TIMESTEPS);

    logic [ACC_W-1:0] v, acc, v_in, v_cur, acc_cur, sum, acc_nxt;
    logic [CW-1:0]    act_x;

    // On load the fresh activation and a zero accumulator feed step 0 directly.
    always_comb begin
        act_x   = CW'(act);
        v_in    = (act_x > T_X) ? T_A : ACC_W'(act_x);
        v_cur   = load ? v_in : v;
        acc_cur = load ? '0 : acc;
        sum     = acc_cur + v_cur;
        spike   = (sum >= T_A);
        acc_nxt = spike ? sum - T_A : sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v   <= '0;
            acc <= '0;
        end else if (load) begin
            v   <= v_in;
            acc <= acc_nxt;
        end else if (step) begin
            acc <= acc_nxt;
        end
    end
endmodule

// File: rtl/ann_to_snn_encoder.sv
// Rate-codes one activation vector into TIMESTEPS spike vectors.
// Optional packed output of the whole window under ANN_TO_SNN_PACKED_EN.
module ann_to_snn_encoder
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int WIDTH       = 3,
    parameter int TIMESTEPS   = TIMESTEPS_DEF,
    localparam int TS_W       = $clog2(TIMESTEPS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_NEURONS*WIDTH-1:0] ann_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    output logic [NUM_NEURONS-1:0]       spike_out,
    output logic                         spike_valid,
    input  logic                         spike_ready,
    output logic [TS_W-1:0]              timestep,
`ifdef ANN_TO_SNN_PACKED_EN
    output logic [NUM_NEURONS*TIMESTEPS-1:0] spikes_packed,
    output logic                             packed_valid,
`endif
    output logic                         last_step
);
    enc_state_t             state, state_nxt;
    logic                   load, adv, done;
    logic [NUM_NEURONS-1:0] spk;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready_out = 1'b0;
        load      = 1'b0;
        adv       = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready_out = 1'b1;
                load      = valid_in;
                if (valid_in) state_nxt = ENCODE;
            end
            ENCODE: begin
                if (spike_valid && spike_ready) begin
                    if (last_step) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_neuron
        ann_to_snn_if_neuron #(.WIDTH(WIDTH), .TIMESTEPS(TIMESTEPS)) u_neuron (
            .clk   (clk),
            .rst   (rst),
            .act   (ann_in[g*WIDTH +: WIDTH]),
            .load  (load),
            .step  (adv),
            .spike (spk[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || done) begin
            spike_out   <= '0;
            spike_valid <= 1'b0;
            timestep    <= '0;
            last_step   <= 1'b0;
        end else if (load) begin
            spike_out   <= spk;
            spike_valid <= 1'b1;
            timestep    <= '0;
            last_step   <= 1'b0;
        end else if (adv) begin
            spike_out   <= spk;
            timestep    <= timestep + 1'b1;
            last_step   <= (timestep == TS_W'(TIMESTEPS - 2));
        end
    end

`ifdef ANN_TO_SNN_PACKED_EN
    logic [NUM_NEURONS*TIMESTEPS-1:0] pack_acc;
    logic [TS_W-1:0]                  t_nxt;

    assign t_nxt = load ? '0 : timestep + 1'b1;

    // Every step slot is rewritten each window, so pack_acc never needs clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            pack_acc      <= '0;
            spikes_packed <= '0;
            packed_valid  <= 1'b0;
        end else begin
            packed_valid <= done;
            if (load || adv)
                for (int n = 0; n < NUM_NEURONS; n++)
                    pack_acc[n*TIMESTEPS + int'(t_nxt)] <= spk[n];
            if (done) spikes_packed <= pack_acc;
        end
    end
`endif
endmodule
